mem_access_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 41 ++++
 rtl/mem_rr_arb.sv | 50 +++++
 rtl/mem_access_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
//   - burst size encodings used on if_size / ls_size
//   - controller FSM state encoding
//   - port ownership encoding used by the arbiter and datapath
//   - size_to_beats(): burst-size code to beat count
package mem_ctrl_pkg;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [1:0]  ACCESS_SIZE_WORD = 2'b00;

  typedef enum logic [1:0] {
    BURST_1  = 2'b00,
    BURST_4  = 2'b01,
    BURST_8  = 2'b10,
    BURST_16 = 2'b11
  } burst_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  function automatic logic [4:0] size_to_beats(input logic [1:0] size);
    logic [4:0] beats;
    case (burst_size_e'(size))
      BURST_1:  beats = 5'd1;
      BURST_4:  beats = 5'd4;
      BURST_8:  beats = 5'd8;
      default:  beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter (fetch vs load/store).
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   enable        - arbitration allowed this cycle (controller idle)
//   req_if/req_ls - request levels
//   gnt_if/gnt_ls - combinational one-hot grant, only while enable is high
//   winner        - owner encoding of the current grant
// last_winner resets to LS so that fetch wins the first tie.
module mem_rr_arb
  import mem_ctrl_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   enable,
  input  logic   req_if,
  input  logic   req_ls,
  output logic   gnt_if,
  output logic   gnt_ls,
  output owner_e winner
);

  owner_e last_winner;

  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (enable) begin
      if (req_if && req_ls) begin
        if (last_winner == OWNER_LS) gnt_if = 1'b1;
        else                         gnt_ls = 1'b1;
      end else if (req_if) begin
        gnt_if = 1'b1;
      end else if (req_ls) begin
        gnt_ls = 1'b1;
      end
    end
    winner = gnt_ls ? OWNER_LS : OWNER_IF;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner <= OWNER_LS;
    end else if (gnt_if) begin
      last_winner <= OWNER_IF;
    end else if (gnt_ls) begin
      last_winner <= OWNER_LS;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates fetch and load/store ports and owns the
// single-word memory port. Bursts of 1/4/8/16 words are split into
// consecutive word accesses; read data is returned one beat per cycle.
// Ports:
//   clock, reset                     - system clock, synchronous active-high reset
//   if_req/if_addr/if_size           - fetch request (level), base byte address, burst code
//   if_gnt/if_rvalid/if_rdata/if_done- fetch grant pulse, read beats, completion pulse
//   ls_req/ls_rw/ls_addr/ls_size/ls_wdata - load/store request (rw=1 write)
//   ls_gnt/ls_rvalid/ls_rdata/ls_done- load/store grant pulse, read beats, completion pulse
//   mem_address/mem_data_in/mem_access_size/mem_rw/mem_enable - memory command
//   mem_busy                         - memory stall, holds the current beat
//   mem_data_out                     - memory read data, MEM_LAT cycles after issue
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_size,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state, state_next;
  owner_e            owner, winner;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        beat, beat_last;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MEM_LAT-1:0] rd_pipe;
  logic              settle;
  logic              arb_en;
  logic              gnt_if_a, gnt_ls_a, gnt_any;
  logic              rd_issue;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [4:0]        sel_beats_m1;
  logic [ADDR_W-1:0] beat_offset;

  // Grants are held off while in reset and for the first cycle after it so
  // that every output reads zero throughout that window.
  assign arb_en = (state == IDLE) && !settle && !reset;

  mem_rr_arb u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_en),
    .req_if (if_req),
    .req_ls (ls_req),
    .gnt_if (gnt_if_a),
    .gnt_ls (gnt_ls_a),
    .winner (winner)
  );

  assign gnt_any      = gnt_if_a || gnt_ls_a;
  assign sel_addr     = gnt_ls_a ? ls_addr : if_addr;
  assign sel_size     = gnt_ls_a ? ls_size : if_size;
  assign sel_beats_m1 = size_to_beats(sel_size) - 5'd1;
  assign beat_offset  = ADDR_W'(beat) * ADDR_W'(WORD_BYTES);
  assign rd_issue     = (state == ISSUE) && !mem_busy && !rw_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    if_gnt          = gnt_if_a;
    ls_gnt          = gnt_ls_a;
    if_done         = 1'b0;
    ls_done         = 1'b0;
    mem_address     = '0;
    mem_data_in     = '0;
    mem_access_size = ACCESS_SIZE_WORD;
    mem_rw          = 1'b0;
    mem_enable      = 1'b0;
    if_rvalid       = 1'b0;
    ls_rvalid       = 1'b0;
    if_rdata        = '0;
    ls_rdata        = '0;

    case (state)
      IDLE: begin
        if (gnt_any) state_next = ISSUE;
      end
      ISSUE: begin
        mem_enable  = 1'b1;
        mem_rw      = rw_q;
        mem_address = base_addr + beat_offset;
        mem_data_in = rw_q ? wdata_q : '0;
        if (!mem_busy && (beat == beat_last)) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        if_done    = (owner == OWNER_IF);
        ls_done    = (owner == OWNER_LS);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Read data is a pass-through of the memory output, qualified by the
    // delayed issue strobe and routed to the port that owns the transaction.
    if (rd_pipe[MEM_LAT-1]) begin
      if (owner == OWNER_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_data_out;
      end else begin
        ls_rvalid = 1'b1;
        ls_rdata  = mem_data_out;
      end
    end

    if (reset) begin
      if_gnt          = 1'b0;
      ls_gnt          = 1'b0;
      if_done         = 1'b0;
      ls_done         = 1'b0;
      mem_address     = '0;
      mem_data_in     = '0;
      mem_access_size = '0;
      mem_rw          = 1'b0;
      mem_enable      = 1'b0;
      if_rvalid       = 1'b0;
      ls_rvalid       = 1'b0;
      if_rdata        = '0;
      ls_rdata        = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      settle    <= 1'b1;
      rd_pipe   <= '0;
      beat      <= '0;
      beat_last <= '0;
      base_addr <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      owner     <= OWNER_IF;
    end else begin
      settle  <= 1'b0;
      rd_pipe <= MEM_LAT'({rd_pipe, rd_issue});
      if (gnt_any) begin
        owner     <= winner;
        base_addr <= {sel_addr[ADDR_W-1:2], 2'b00};
        rw_q      <= gnt_ls_a && ls_rw;
        wdata_q   <= gnt_ls_a ? ls_wdata : '0;
        beat      <= '0;
        beat_last <= (gnt_ls_a && ls_rw) ? 4'd0 : sel_beats_m1[3:0];
      end else if ((state == ISSUE) && !mem_busy && (beat != beat_last)) begin
        beat <= beat + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [1:0]  if_size;
  logic        if_gnt, if_rvalid, if_done;
  logic [31:0] if_rdata;
  logic        ls_req, ls_rw;
  logic [31:0] ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        ls_gnt, ls_rvalid, ls_done;
  logic [31:0] ls_rdata;
  logic [31:0] mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } beat_t;

  acc_t  exp_acc[$];
  beat_t exp_beat[$];

  logic [137:0] all_out;
  assign all_out = {if_gnt, if_rvalid, if_rdata, if_done, ls_gnt, ls_rvalid, ls_rdata, ls_done,
                    mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable};

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_size(ls_size), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: a read accepted in one cycle returns its data in the next.
  logic        nxt_v;
  logic [31:0] nxt_d;
  always @(negedge clock) begin
    nxt_v = mem_enable && !mem_busy && !mem_rw;
    nxt_d = memf(mem_address);
  end
  always @(posedge clock) begin
    #1 mem_data_out = nxt_v ? nxt_d : 32'hC0DE_0BAD;
  end

  // Scoreboard monitor: memory commands and read beats against the queues.
  always @(negedge clock) begin
    acc_t  e;
    beat_t b;
    if (!reset) begin
      if (mem_enable) begin
        vectors++;
        if (exp_acc.size() == 0) begin
          miscompares++;
          $display("FAIL mem_cmd_unexpected: addr=%h rw=%b", mem_address, mem_rw);
        end else begin
          e = exp_acc[0];
          if ({mem_address, mem_rw, mem_data_in, mem_access_size} !== {e.addr, e.rw, e.wdata, 2'b00}) begin
            miscompares++;
            $display("FAIL mem_cmd: got addr=%h rw=%b wd=%h sz=%b, want addr=%h rw=%b wd=%h sz=00",
                     mem_address, mem_rw, mem_data_in, mem_access_size, e.addr, e.rw, e.wdata);
          end
          if (!mem_busy) void'(exp_acc.pop_front());
        end
      end
      if (if_rvalid || ls_rvalid) begin
        vectors++;
        if (exp_beat.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid_unexpected: if_rvalid=%b ls_rvalid=%b", if_rvalid, ls_rvalid);
        end else begin
          b = exp_beat.pop_front();
          if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !==
              {!b.port, b.port, (b.port ? 32'h0 : b.data), (b.port ? b.data : 32'h0)}) begin
            miscompares++;
            $display("FAIL rbeat: got v=%b%b ifd=%h lsd=%h, want port=%0d data=%h",
                     if_rvalid, ls_rvalid, if_rdata, ls_rdata, b.port, b.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic [31:0] base, input logic [1:0] size,
                          input logic rw, input logic [31:0] wdata);
    int n;
    acc_t e;
    beat_t b;
    n = rw ? 1 : (size == 2'd0 ? 1 : size == 2'd1 ? 4 : size == 2'd2 ? 8 : 16);
    for (int i = 0; i < n; i++) begin
      e.addr  = {base[31:2], 2'b00} + 32'(i * 4);
      e.rw    = rw;
      e.wdata = rw ? wdata : 32'h0;
      exp_acc.push_back(e);
      if (!rw) begin
        b.port = port;
        b.data = memf(e.addr);
        exp_beat.push_back(b);
      end
    end
  endtask

  // Waits for the grant, applies the stall schedule (cycles after the grant)
  // and checks the done pulse arrives the expected number of cycles later.
  task automatic run_txn(input logic port, input int n_beats, input int stall_a,
                         input int stall_b, input bit drop);
    bit got;
    int k, exp_delta;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (if_gnt || ls_gnt) got = 1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL grant_timeout: no grant, want port=%0d", port);
      return;
    end
    if ({if_gnt, ls_gnt} !== {!port, port}) begin
      miscompares++;
      $display("FAIL grant_port: got if_gnt=%b ls_gnt=%b, want port=%0d", if_gnt, ls_gnt, port);
    end
    exp_delta = n_beats + 2 + (stall_a > 0 ? 1 : 0) + (stall_b > 0 ? 1 : 0);
    got = 0;
    k = 0;
    while (!got && k < 60) begin
      @(posedge clock); #1;
      k++;
      if (k == 1 && drop) begin
        if_req = 1'b0;
        ls_req = 1'b0;
      end
      mem_busy = (k == stall_a) || (k == stall_b);
      @(negedge clock);
      if (if_done || ls_done) got = 1;
    end
    mem_busy = 1'b0;
    vectors++;
    if (!got || k != exp_delta || {if_done, ls_done} !== {!port, port}) begin
      miscompares++;
      $display("FAIL done_timing: got delta=%0d done=%b%b, want delta=%0d port=%0d",
               k, if_done, ls_done, exp_delta, port);
    end
    vectors++;
    if (exp_acc.size() != 0 || exp_beat.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got acc=%0d beats=%0d outstanding, want 0",
               exp_acc.size(), exp_beat.size());
    end
    if (drop) begin
      @(negedge clock);
      vectors++;
      if (if_done || ls_done) begin
        miscompares++;
        $display("FAIL done_pulse_width: got done=%b%b after pulse, want 00", if_done, ls_done);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 1'b1; ls_req = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL post_reset_outputs: got %h, want 0", all_out);
    end
    @(posedge clock); #1 if_req = 1'b0; ls_req = 1'b0;
    @(negedge clock);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h, want 0", all_out);
    end
  endtask

  task automatic test_round_robin();
    @(posedge clock); #1;
    if_addr = 32'h0000_1000; if_size = 2'b00;
    ls_addr = 32'h0000_2002; ls_size = 2'b00; ls_rw = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    push_exp(1'b0, 32'h0000_1000, 2'b00, 1'b0, 32'h0);
    run_txn(1'b0, 1, 0, 0, 1'b0);
    push_exp(1'b1, 32'h0000_2002, 2'b00, 1'b0, 32'h0);
    run_txn(1'b1, 1, 0, 0, 1'b0);
    push_exp(1'b0, 32'h0000_1000, 2'b00, 1'b0, 32'h0);
    run_txn(1'b0, 1, 0, 0, 1'b1);
  endtask

  task automatic test_fetch_burst();
    @(posedge clock); #1;
    if_addr = 32'h8002_0000; if_size = 2'b01; if_req = 1'b1;
    push_exp(1'b0, if_addr, if_size, 1'b0, 32'h0);
    run_txn(1'b0, 4, 0, 0, 1'b1);
  endtask

  task automatic test_ls_write();
    @(posedge clock); #1;
    ls_addr = 32'h8002_0013; ls_wdata = 32'hDEAD_BEEF; ls_rw = 1'b1; ls_size = 2'b11; ls_req = 1'b1;
    push_exp(1'b1, ls_addr, ls_size, 1'b1, ls_wdata);
    run_txn(1'b1, 1, 0, 0, 1'b1);
    ls_rw = 1'b0;
  endtask

  task automatic test_stall_burst();
    @(posedge clock); #1;
    ls_addr = 32'h8003_0040; ls_size = 2'b10; ls_rw = 1'b0; ls_req = 1'b1;
    push_exp(1'b1, ls_addr, ls_size, 1'b0, 32'h0);
    run_txn(1'b1, 8, 3, 7, 1'b1);
  endtask

  task automatic test_wrap();
    @(posedge clock); #1;
    if_addr = 32'hFFFF_FFF8; if_size = 2'b01; if_req = 1'b1;
    push_exp(1'b0, if_addr, if_size, 1'b0, 32'h0);
    run_txn(1'b0, 4, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    int bad;
    @(posedge clock); #1;
    if_addr = 32'h8005_0000; if_size = 2'b11; if_req = 1'b1;
    push_exp(1'b0, if_addr, if_size, 1'b0, 32'h0);
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (if_gnt) got = 1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rst_burst_grant: no fetch grant, want one");
    end
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
      if (k == 1) if_req = 1'b0;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    exp_acc.delete();
    exp_beat.delete();
    @(negedge clock);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL rst_burst_during: got %h, want 0", all_out);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL rst_burst_after: got %h, want 0", all_out);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (all_out !== '0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_burst_quiet: got %0d active cycles, want 0", bad);
    end
    @(posedge clock); #1;
    ls_addr = 32'h8004_0000; ls_size = 2'b01; ls_rw = 1'b0; ls_req = 1'b1;
    push_exp(1'b1, ls_addr, ls_size, 1'b0, 32'h0);
    run_txn(1'b1, 4, 0, 0, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; if_size = '0;
    ls_req = 1'b0; ls_rw = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
    mem_busy = 1'b0; mem_data_out = '0;
    test_reset();
    test_round_robin();
    test_fetch_burst();
    test_ls_write();
    test_stall_burst();
    test_wrap();
    test_reset_mid_burst();
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
